// File: rtl/hit_detector.sv
// Detects Mario's collisions with the active barrel (loss) and with the Queen (win),
// filtered by a grace period after game start and by per-tick persistence counters.
module hit_detector #(
   parameter int unsigned MARIO_W     = 34,
   parameter int unsigned MARIO_H     = 36,
   parameter int unsigned QUEUE_W     = 44,
   parameter int unsigned QUEUE_H     = 50,
   parameter int unsigned HIT_MARGIN  = 4,
   parameter int unsigned HIT_CONFIRM = 2,
   parameter int unsigned WIN_CONFIRM = 4,
   parameter int unsigned GRACE_TICKS = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       running,
   input  logic [9:0] mario_x,
   input  logic [8:0] mario_y,
   input  logic [9:0] barrel_x,
   input  logic [8:0] barrel_y,
   input  logic [9:0] barrel_w,
   input  logic [8:0] barrel_h,
   input  logic [9:0] queue_x,
   input  logic [8:0] queue_y,
   output logic       over,
   output logic       success,
   output logic [3:0] hit_cnt
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRACE,
      ST_ARMED,
      ST_OVER,
      ST_WIN
   } state_t;

   localparam logic [10:0] HIT_LO     = 11'(HIT_MARGIN);
   localparam logic [10:0] HIT_HI_X   = 11'(MARIO_W - HIT_MARGIN);
   localparam logic [10:0] HIT_HI_Y   = 11'(MARIO_H - HIT_MARGIN);
   localparam logic [10:0] Q_HALF_W   = 11'(QUEUE_W / 2);
   localparam logic [10:0] Q_HALF_H   = 11'(QUEUE_H / 2);
   localparam logic [10:0] WIN_SPAN_X = 11'(MARIO_W + QUEUE_W / 2);
   localparam logic [10:0] WIN_SPAN_Y = 11'(MARIO_H + QUEUE_H / 2);
   localparam logic [3:0]  HIT_NEED   = 4'(HIT_CONFIRM);
   localparam logic [3:0]  WIN_NEED   = 4'(WIN_CONFIRM);
   localparam logic [7:0]  GRACE_LOAD = 8'(GRACE_TICKS);

   // Everything widened to 11 bits so no sum below can wrap.
   logic [10:0] mx, my, bx, by, bw, bh, qx, qy;
   assign mx = {1'b0, mario_x};
   assign my = {2'b00, mario_y};
   assign bx = {1'b0, barrel_x};
   assign by = {2'b00, barrel_y};
   assign bw = {1'b0, barrel_w};
   assign bh = {2'b00, barrel_h};
   assign qx = {1'b0, queue_x};
   assign qy = {2'b00, queue_y};

   logic hit_now, win_now;
   assign hit_now = (mx + HIT_LO < bx + bw) && (bx < mx + HIT_HI_X)
                 && (my + HIT_LO < by + bh) && (by < my + HIT_HI_Y);
   assign win_now = (mx < qx + Q_HALF_W) && (qx < mx + WIN_SPAN_X)
                 && (my < qy + Q_HALF_H) && (qy < my + WIN_SPAN_Y);

   logic tick_d, samp, upd, hit_ov, win_ov;
   assign samp = tick & ~tick_d;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         tick_d <= 1'b0;
         upd    <= 1'b0;
         hit_ov <= 1'b0;
         win_ov <= 1'b0;
      end else begin
         tick_d <= tick;
         upd    <= samp;
         if (samp) begin
            hit_ov <= hit_now;
            win_ov <= win_now;
         end
      end
   end

   state_t     state;
   logic [3:0] win_cnt;
   logic [7:0] grace_cnt;
   logic [3:0] hit_next, win_next;

   assign hit_next = !hit_ov ? 4'd0 : (hit_cnt == 4'd15) ? 4'd15 : hit_cnt + 4'd1;
   assign win_next = !win_ov ? 4'd0 : (win_cnt == 4'd15) ? 4'd15 : win_cnt + 4'd1;

   // NOTE: reset is synchronous; dropping running uses the same clear path and
   // takes priority over any stage-2 update pending in that cycle.
   always_ff @(posedge clk) begin
      if (!rst || !running) begin
         state     <= ST_IDLE;
         over      <= 1'b0;
         success   <= 1'b0;
         hit_cnt   <= 4'd0;
         win_cnt   <= 4'd0;
         grace_cnt <= 8'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (GRACE_LOAD == 8'd0) begin
                  state <= ST_ARMED;
               end else begin
                  state     <= ST_GRACE;
                  grace_cnt <= GRACE_LOAD;
               end
            end
            ST_GRACE: begin
               if (upd) begin
                  win_cnt   <= win_next;
                  grace_cnt <= grace_cnt - 8'd1;
                  if (win_next >= WIN_NEED) begin
                     state   <= ST_WIN;
                     success <= 1'b1;
                  end else if (grace_cnt == 8'd1) begin
                     state <= ST_ARMED;
                  end
               end
            end
            ST_ARMED: begin
               if (upd) begin
                  hit_cnt <= hit_next;
                  win_cnt <= win_next;
                  if (hit_next >= HIT_NEED) begin
                     state <= ST_OVER;
                     over  <= 1'b1;
                  end else if (win_next >= WIN_NEED) begin
                     state   <= ST_WIN;
                     success <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
